piso_shift_tx: RTL

//   Parallel-in/serial-out transmit register. Accepts WIDTH-bit words on a valid/ready

---
 rtl/piso_shift_tx_pkg.sv | 18 +
 rtl/piso_hold_stage.sv | 34 +++
 rtl/piso_shift_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/piso_shift_tx_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_shift_tx_pkg;

    // Transmit state: IDLE waits for a held word, SHIFT drives serial bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    // Bit-index counter width for a given word width (at least one bit).
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_stage.sv
// One-entry holding buffer in front of the shifter. A load captures a word and
// sets the valid flag; a clear frees the slot once the shifter has taken it.
// The owner never asserts load and clear together: load is gated by ready,
// clear only happens while valid is set.
module piso_hold_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ready
);

    // Capture on load, release on clear; reset empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Ready is purely a function of occupancy, so no path from the serial side.
    assign ready = ~valid;

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmit register. Words enter through a one-entry
// hold stage and are shifted out one bit per serial handshake. When the hold
// stage is full at the last bit of a word, the next word is reloaded on the
// same edge so consecutive words stream without an idle bit.
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    input  logic             ser_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("piso_shift_tx: WIDTH must be in 2..64");
    end

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] shifter_nxt;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             hold_load;
    logic             hold_clear;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             hold_ready;
    logic             bit_taken;

    piso_hold_stage #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hold_load),
        .clear   (hold_clear),
        .data_in (s_data_i),
        .data    (hold_data),
        .valid   (hold_valid),
        .ready   (hold_ready)
    );

    assign s_ready_o = hold_ready;
    assign hold_load = s_valid_i & hold_ready;

    // Shift toward the transmitted end, filling with zero.
    always_comb begin
        shifted = '0;
        if (LSB_FIRST != 0) begin
            shifted = {1'b0, shifter[WIDTH-1:1]};
        end else begin
            shifted = {shifter[WIDTH-2:0], 1'b0};
        end
    end

    assign ser_valid_o = (state == SHIFT);
    assign bit_taken   = ser_valid_o & ser_ready_i;
    assign busy_o      = ser_valid_o | hold_valid;

    // Serial bit is forced low outside SHIFT so idle/reset read back as zero.
    always_comb begin
        ser_o = 1'b0;
        if (state == SHIFT) begin
            ser_o = (LSB_FIRST != 0) ? shifter[0] : shifter[WIDTH-1];
        end
    end

    // Next-state, shifter, counter and hold-release decisions.
    always_comb begin
        state_nxt   = state;
        shifter_nxt = shifter;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        hold_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    shifter_nxt = hold_data;
                    cnt_nxt     = '0;
                    hold_clear  = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_taken) begin
                    if (cnt == LAST_IDX) begin
                        done_nxt = 1'b1;
                        cnt_nxt  = '0;
                        if (hold_valid) begin
                            shifter_nxt = hold_data;
                            hold_clear  = 1'b1;
                        end else begin
                            shifter_nxt = shifted;
                            state_nxt   = IDLE;
                        end
                    end else begin
                        shifter_nxt = shifted;
                        cnt_nxt     = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shifter <= '0;
            cnt     <= '0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shifter <= shifter_nxt;
            cnt     <= cnt_nxt;
            done_o  <= done_nxt;
        end
    end

endmodule
